// File: rtl/crc_pkg.sv
// Shared CRC settings for crc_generator and crc_validator.
// Both ends of the link import these values, so they agree on the polynomial and the field widths.
package crc_pkg;

  // Payload width in bits.
  localparam int DEF_DATA_W = 8;

  // CRC width in bits.
  localparam int DEF_CRC_W = 4;

  // Low CRC_W bits of the generator polynomial. The x^CRC_W term is implicit.
  // 4'h3 selects x^4 + x + 1.
  localparam logic [DEF_CRC_W-1:0] DEF_POLY = 4'h3;

  // Width of the systematic codeword {payload, crc}.
  localparam int DEF_CODE_W = DEF_DATA_W + DEF_CRC_W;

endpackage : crc_pkg

// File: rtl/crc_generator.sv
// Bit-serial CRC encoder.
// It shifts one payload bit per clock into an LFSR, MSB first, and then presents the systematic
// codeword {payload, crc}.
//
// Handshake: start is a single-cycle request and is accepted in IDLE or DONE, never in SHIFT.
// On the accepting edge the payload is latched, busy rises and done falls.
// Exactly DATA_W cycles later busy falls, done rises and codeword_out is loaded.
// done stays high, and codeword_out stays stable, until the next accepted start or rst.
module crc_generator
  import crc_pkg::*;
#(
  parameter int              DATA_W = DEF_DATA_W,
  parameter int              CRC_W  = DEF_CRC_W,
  parameter logic [CRC_W-1:0] POLY  = DEF_POLY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     busy,
  output logic [DATA_W+CRC_W-1:0]  codeword_out,
  output logic                     done
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int CODE_W = DATA_W + CRC_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   payload_q;
  logic [CRC_W-1:0]    crc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CODE_W-1:0]   codeword_q;

  logic                accept;
  logic                last_step;
  logic [DATA_W-1:0]   payload_shifted;
  logic                cur_bit;
  logic [CRC_W-1:0]    crc_next;

  // One LFSR step: fold the incoming message bit into the top of the remainder.
  // Because the bit enters at the MSB, no augmentation cycles are needed afterwards.
  function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] crc,
                                                 input logic             b);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  // A start is honoured only when no computation is running.
  assign accept    = start && (state_q != S_SHIFT);

  // The edge that performs step DATA_W is the one that leaves SHIFT.
  assign last_step = (state_q == S_SHIFT) && (cnt_q == CNT_W'(DATA_W - 1));

  // Select payload bit [DATA_W-1-count] by shifting instead of indexing.
  // This keeps the payload register itself untouched.
  assign payload_shifted = payload_q << cnt_q;
  assign cur_bit         = payload_shifted[DATA_W-1];
  assign crc_next        = lfsr_step(crc_q, cur_bit);

  // State register, with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE/DONE -> SHIFT on start, SHIFT -> DONE after DATA_W steps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_SHIFT;
      S_SHIFT: if (last_step) state_d = S_DONE;
      S_DONE:  if (start)     state_d = S_SHIFT;
      default:                state_d = S_IDLE;
    endcase
  end

  // Output decode.
  // busy and done are taken straight from the state flops, so inputs have no combinational path
  // to the outputs.
  always_comb begin
    busy         = (state_q == S_SHIFT);
    done         = (state_q == S_DONE);
    codeword_out = codeword_q;
  end

  // Datapath: latch the payload on accept, step the LFSR in SHIFT, and publish the codeword only
  // on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      payload_q  <= '0;
      crc_q      <= '0;
      cnt_q      <= '0;
      codeword_q <= '0;
    end else if (accept) begin
      payload_q <= data_in;
      crc_q     <= '0;
      cnt_q     <= '0;
    end else if (state_q == S_SHIFT) begin
      crc_q <= crc_next;
      cnt_q <= cnt_q + 1'b1;
      if (last_step) begin
        codeword_q <= {payload_q, crc_next};
      end
    end
  end

endmodule : crc_generator

// File: tb/tb_crc_generator.sv
// Self-checking bench for crc_generator.
// It uses directed vectors with literal expected codewords, plus a per-cycle comparison against a
// behavioural model.
// The model derives the CRC by polynomial long division on the augmented payload.
module tb_crc_generator;
  import crc_pkg::*;

  localparam int DATA_W = DEF_DATA_W;
  localparam int CRC_W  = DEF_CRC_W;
  localparam int CODE_W = DEF_CODE_W;

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic [CODE_W-1:0] codeword_out;
  logic              done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  crc_generator dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data_in      (data_in),
    .busy         (busy),
    .codeword_out (codeword_out),
    .done         (done)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Remainder of v modulo the full generator polynomial, by schoolbook long division.
  function automatic logic [CRC_W-1:0] div_rem(input logic [CODE_W-1:0] v);
    logic [CODE_W-1:0] r;
    logic [CODE_W-1:0] g;
    r = v;
    g = {{(CODE_W-CRC_W-1){1'b0}}, 1'b1, DEF_POLY};
    for (int i = CODE_W - 1; i >= CRC_W; i--) begin
      if (r[i]) r = r ^ (g << (i - CRC_W));
    end
    return r[CRC_W-1:0];
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    return {d, div_rem({d, {CRC_W{1'b0}}})};
  endfunction

  // ---------------- behavioural model ----------------
  // m_left counts the cycles still to run.
  // A start is taken whenever nothing is pending.
  int                m_left      = 0;
  logic              m_done      = 1'b0;
  logic [CODE_W-1:0] m_cw        = '0;
  logic [CODE_W-1:0] m_pending   = '0;
  bit                model_ready = 1'b0;
  logic [CODE_W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_cw   = '0;
      exp_q.delete();
    end else if (start && m_left == 0) begin
      m_left    = DATA_W;
      m_pending = encode(data_in);
      m_done    = 1'b0;
      exp_q.push_back(m_pending);
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_cw   = m_pending;
      end
    end
    model_ready = 1'b1;
  end

  // ---------------- scoreboard / compare ----------------
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (model_ready) begin
      check("busy", busy, m_left > 0);
      check("done", done, m_done);
      check("codeword", codeword_out, m_cw);
      if (done === 1'b1 && prev_done === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          check("sb_word", codeword_out, exp_q.pop_front());
        end
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  // Both tasks are called at a negedge and return at a negedge.
  task automatic start_word(input logic [DATA_W-1:0] d);
    start   = 1'b1;
    data_in = d;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cycles);
    int k;
    for (k = 0; k < 40 && done !== 1'b1; k++) @(negedge clk);
    cycles = k;
    check({name, "_done"}, done, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    int pos;
    logic [DATA_W-1:0] d;

    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cw", codeword_out, 12'h000);

    // Basic run: 8'hCC -> 12'hCCE, with 8-cycle latency, then held for 20 cycles.
    start_word(8'hCC);
    check("cc_busy", busy, 1'b1);
    wait_done("cc", lat);
    check("cc_latency", lat, 8);
    check("cc_cw", codeword_out, 12'hCCE);
    repeat (20) @(negedge clk);
    check("cc_hold_done", done, 1'b1);
    check("cc_hold_cw", codeword_out, 12'hCCE);

    // More patterns, each started back-to-back from DONE.
    start_word(8'hAA);
    wait_done("aa", lat);
    check("aa_cw", codeword_out, 12'hAA9);
    start_word(8'hFF);
    wait_done("ff", lat);
    check("ff_cw", codeword_out, 12'hFF4);
    start_word(8'h00);
    wait_done("zero", lat);
    check("zero_cw", codeword_out, 12'h000);

    // A start during SHIFT is ignored.
    start_word(8'hCC);
    repeat (2) @(negedge clk);
    start_word(8'hAA);
    wait_done("ign", lat);
    check("ign_cw", codeword_out, 12'hCCE);

    // Restart from DONE: the old word stays visible until the new one completes.
    start_word(8'hAA);
    check("rs_done_low", done, 1'b0);
    check("rs_busy", busy, 1'b1);
    check("rs_cw_kept", codeword_out, 12'hCCE);
    repeat (4) @(negedge clk);
    check("rs_cw_mid", codeword_out, 12'hCCE);
    wait_done("rs", lat);
    check("rs_cw", codeword_out, 12'hAA9);

    // Reset in the middle of SHIFT.
    start_word(8'hCC);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_busy", busy, 1'b0);
    check("mr_done", done, 1'b0);
    check("mr_cw", codeword_out, 12'h000);
    repeat (10) @(negedge clk);
    check("mr_idle_done", done, 1'b0);
    start_word(8'hCC);
    wait_done("mr", lat);
    check("mr_cw_after", codeword_out, 12'hCCE);

    // Loopback: every codeword divides evenly, and any single-bit flip is detected.
    for (int n = 0; n < 16; n++) begin
      d = DATA_W'($urandom_range(0, 255));
      start_word(d);
      wait_done("lb", lat);
      check("lb_payload", codeword_out[CODE_W-1:CRC_W], d);
      check("lb_rem", div_rem(codeword_out), '0);
      pos = $urandom_range(0, CODE_W - 1);
      check("lb_flip", div_rem(codeword_out ^ (CODE_W'(1) << pos)) != '0, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_crc_generator

// File: doc/crc_generator.md
Name: crc_generator

Overview:
Bit-serial CRC encoder that sits directly upstream of crc_validator. It accepts a DATA_W-bit payload and computes the CRC-CRC_W remainder, one bit per clock, MSB first. It presents the systematic codeword {payload, crc}, which crc_validator consumes on its data_in. With the defaults, the 8-bit payload plus CRC-4 (x^4+x+1) produces the 12-bit codeword that crc_validator checks.

Parameters:
DATA_W, 8, payload width in bits
CRC_W, 4, CRC width in bits
POLY, 4'h3, generator polynomial low CRC_W bits (implicit x^CRC_W term); 4'h3 = x^4+x+1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request; payload sampled when accepted
data_in  input  DATA_W  payload to encode
busy  output  1  high while the CRC is being computed
codeword_out  output  DATA_W+CRC_W  {payload, crc}; valid while done is high
done  output  1  level; high from completion until the next accepted start or rst

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, codeword_out=0, crc register=0, bit counter=0. rst overrides start in the same cycle.
- States:
  - IDLE: outputs as at reset; waits for start.
  - SHIFT: computes the CRC, one payload bit per cycle.
  - DONE: holds the result.
- Start acceptance:
  - start is accepted only in IDLE or DONE.
  - On the accepting edge: latch data_in into the payload register, clear crc to 0, clear the counter, go to SHIFT.
  - At that edge busy rises and done falls.
  - start while in SHIFT is ignored; the payload register is not disturbed.
- SHIFT step, per cycle, with b = payload bit [DATA_W-1-count]:
  - fb = crc[CRC_W-1] ^ b
  - crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : 0)
  - count increments.
  - After the DATA_W-th step, crc equals the remainder of payload·x^CRC_W mod P. No augmentation cycles are needed.
- Exit from SHIFT: on the edge that performs step DATA_W, go to DONE. At that edge busy falls, done rises, and codeword_out = {payload, crc_next}.
- Latency: start sampled at edge N; done=1 and codeword_out valid after edge N+DATA_W (8 cycles by default). busy is high for exactly DATA_W cycles.
- DONE: codeword_out and done are held stable indefinitely. start in DONE begins a new computation immediately (back-to-back throughput of DATA_W cycles per word).
- codeword_out changes only on entry to DONE or on reset. It is not updated during SHIFT, and it keeps the previous word while the next one is computed.
- Counter is ceil(log2(DATA_W+1)) bits wide and does not wrap during a computation.
- Reset mid-SHIFT: abandon the computation, return to IDLE, clear all outputs. No partial result is ever presented.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package crc_pkg holds DATA_W, CRC_W and POLY defaults plus a CODE_W = DATA_W+CRC_W constant. crc_validator imports the same package so both ends agree on polynomial and widths.
- State encoding (IDLE/SHIFT/DONE) stays local to the module.
- No sub-module: the single-step LFSR update is a local function, not a separate instance.

Test Plan:
- Reset, then start with data_in=8'hCC -> busy high for 8 cycles; done rises 8 cycles after the start edge with codeword_out=12'hCCE, held stable for 20 further cycles.
- Start with data_in=8'hAA -> codeword_out=12'hAA9. Also start with 8'hFF -> 12'hFF4, and with 8'h00 -> 12'h000.
- Start with 8'hCC, then pulse start with 8'hAA at cycle 3 of SHIFT -> second start ignored; result 12'hCCE.
- In DONE holding 12'hCCE, start with 8'hAA -> done falls at the start edge and codeword_out stays 12'hCCE until done re-rises with 12'hAA9 8 cycles later.
- Assert rst at cycle 4 of SHIFT -> next cycle busy=0, done=0, codeword_out=0; a fresh start with 8'hCC then yields 12'hCCE.
- Loopback: drive crc_validator.data_in from codeword_out for 16 random payloads -> validator reports valid=1 for every word. Flip any single codeword bit -> valid=0.
